// File: rtl/store_pkg.sv
// Shared definitions for the store read-modify-write path: store op
// encodings, FSM state type and the request legality check.
package store_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] ST_SB = 3'b000;
    localparam logic [OP_W-1:0] ST_SH = 3'b010;
    localparam logic [OP_W-1:0] ST_SW = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Reserved ops and misaligned sh/sw are rejected without a memory access.
    function automatic logic op_reject(input logic [OP_W-1:0] op, input logic [1:0] lo);
        logic rej;
        case (op)
            ST_SB:   rej = 1'b0;
            ST_SH:   rej = lo[0];
            ST_SW:   rej = (lo != 2'b00);
            default: rej = 1'b1;
        endcase
        return rej;
    endfunction

endpackage

// File: rtl/store_merge.sv
// Splices a store byte or halfword into the old memory word; any other op
// passes the old word through unchanged.
module store_merge
    import store_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [1:0]      lane,
    input  logic [XLEN-1:0] old_word,
    input  logic [15:0]     new_data,
    output logic [XLEN-1:0] merged_c
);

    always_comb begin
        merged_c = old_word;
        case (op)
            ST_SB:   merged_c[{lane, 3'b000} +: 8]      = new_data[7:0];
            ST_SH:   merged_c[{lane[1], 4'b0000} +: 16] = new_data;
            default: ;
        endcase
    end

endmodule

// File: rtl/store_rmw.sv
// Store unit for a data memory without byte strobes: sw writes directly,
// sb/sh read the old word, merge the new lane and write the word back.
module store_rmw
    import store_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [OP_W-1:0] req_op,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_data,
    output logic            done,
    output logic            err,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_rd,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_rvalid,
    output logic            mem_wr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_wack
);

    state_t          state, state_next;
    logic [OP_W-1:0] op_q, op_next;
    logic [1:0]      lane_q, lane_next;
    logic [15:0]     data_q, data_next;
    logic [XLEN-1:0] addr_next, wdata_next;
    logic            ready_next, done_next, err_next, rd_next, wr_next;
    logic [XLEN-1:0] merged_c;

    store_merge u_merge (
        .op       (op_q),
        .lane     (lane_q),
        .old_word (mem_rdata),
        .new_data (data_q),
        .merged_c (merged_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            lane_q    <= '0;
            data_q    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            req_ready <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
        end else begin
            state     <= state_next;
            op_q      <= op_next;
            lane_q    <= lane_next;
            data_q    <= data_next;
            mem_addr  <= addr_next;
            mem_wdata <= wdata_next;
            req_ready <= ready_next;
            done      <= done_next;
            err       <= err_next;
            mem_rd    <= rd_next;
            mem_wr    <= wr_next;
        end
    end

    always_comb begin
        state_next = state;
        op_next    = op_q;
        lane_next  = lane_q;
        data_next  = data_q;
        addr_next  = mem_addr;
        wdata_next = mem_wdata;
        done_next  = 1'b0;
        err_next   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    op_next   = req_op;
                    lane_next = req_addr[1:0];
                    data_next = req_data[15:0];
                    if (op_reject(req_op, req_addr[1:0])) begin
                        err_next = 1'b1;
                    end else begin
                        addr_next = {req_addr[XLEN-1:2], 2'b00};
                        if (req_op == ST_SW) begin
                            wdata_next = req_data;
                            state_next = ST_WRITE;
                        end else begin
                            state_next = ST_READ;
                        end
                    end
                end
            end
            ST_READ: begin
                if (mem_rvalid) begin
                    wdata_next = merged_c;
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (mem_wack) begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Handshake outputs follow the state being entered so they are registered.
        ready_next = (state_next == ST_IDLE);
        rd_next    = (state_next == ST_READ);
        wr_next    = (state_next == ST_WRITE);
    end

endmodule

// File: doc/store_rmw.md
# store_rmw

Store-side counterpart to the load extraction path: accepts one store request (sb/sh/sw) from the CPU datapath and writes it to a word-wide data memory that has no byte strobes. Sub-word stores use read-modify-write: fetch the old word, splice the new byte or halfword into the correct lane, then write the whole word back. The block sits between the CPU memory stage and the data-memory port. It stalls the CPU through `req_ready` until the write completes.

## Interface
- No parameters; data and address widths are fixed at 32.
- `clk` in 1: single clock, all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: store request present.
- `req_ready` out 1: block idle and able to accept a request.
- `req_op` in 3: `000` sb, `010` sh, `100` sw; every other code is reserved.
- `req_addr` in 32: byte address.
- `req_data` in 32: store data, low bits used for sb/sh.
- `done` out 1: one-cycle pulse when a store has completed.
- `err` out 1: one-cycle pulse when a request is rejected (misaligned or reserved op).
- `mem_addr` out 32: word address, `{addr[31:2],2'b00}`.
- `mem_rd` out 1: read request, held until `mem_rvalid`.
- `mem_rdata` in 32: read data, valid when `mem_rvalid`=1.
- `mem_rvalid` in 1: read data valid.
- `mem_wr` out 1: write request, held until `mem_wack`.
- `mem_wdata` out 32: full word to write.
- `mem_wack` in 1: write accepted.

## Operation
- States: IDLE, READ, WRITE.
- IDLE:
  - `req_ready`=1.
  - When `req_valid`=1, latch op, addr and data.
- Error check at acceptance; a rejected request pulses `err`, returns to IDLE and issues no memory access. Rejected cases:
  - reserved op;
  - sh with `addr[0]`=1;
  - sw with `addr[1:0]`≠0.
- Legal sw: go directly to WRITE with `mem_wdata`=`req_data`.
- Legal sb/sh: go to READ.
- READ:
  - `mem_rd`=1 until `mem_rvalid`.
  - On `mem_rvalid`, register the merged word into `mem_wdata`, then go to WRITE.
  - sb merge: replace byte lane `addr[1:0]` (lane 0 = bits 7:0) with `data[7:0]`.
  - sh merge: replace halfword `addr[1]` (0 = bits 15:0) with `data[15:0]`.
  - All other bits come from `mem_rdata`.
- WRITE:
  - `mem_wr`=1 until `mem_wack`.
  - On `mem_wack`, go to IDLE and pulse `done` in the next cycle.
- `mem_rvalid` outside READ and `mem_wack` outside WRITE are ignored.
- `mem_addr` and `mem_wdata` are registered and hold stable for the whole access.
- Only one transaction is in flight at a time; there is no buffering beyond the latched request.

## Timing
- Reset values: `req_ready`=1; `done`, `err`, `mem_rd`, `mem_wr` = 0; `mem_addr` and `mem_wdata` = 0; state IDLE.
- Notation: request accepted in cycle T.
- Rejected request:
  - `err`=1 in T+1 only.
  - `req_ready`=1 again in T+1, so back-to-back requests are allowed.
- sw:
  - `mem_wr`=1 from T+1.
  - With a zero-wait `mem_wack` in T+1: `done` and `req_ready`=1 in T+2.
- sb/sh:
  - `mem_rd`=1 from T+1.
  - With `mem_rvalid` in T+1: `mem_wr`=1 in T+2.
  - With `mem_wack` in T+2: `done` and `req_ready`=1 in T+3.
- Each wait cycle on `mem_rvalid` or `mem_wack` adds one cycle.
- `mem_rd` and `mem_wr` are never high in the same cycle.
- `req_ready`=0 in READ and WRITE. It rises in the same cycle `done` pulses, and a new request may be accepted in that cycle.
- Reset mid-transaction: outputs return to reset values immediately (asynchronous). The transaction is dropped with no `done` and no `err`.

## Structure
- Package `store_pkg` holds:
  - op encodings `ST_SB`, `ST_SH`, `ST_SW`;
  - state enum `{ST_IDLE, ST_READ, ST_WRITE}`.
- Sub-module `store_merge`: combinational, inputs (op, `addr[1:0]`, old word, new data), output merged word. It is used in READ and unit-tested on its own.
- The FSM and registers live in `store_rmw`.

## Test plan
- sw, addr `0x100`, data `0xDEADBEEF`, `mem_wack` immediate:
  - `mem_addr`=`0x100`, `mem_wdata`=`0xDEADBEEF` in T+1;
  - `done` in T+2;
  - `mem_rd` never asserted.
- sb, addr `0x203`, data `0x000000AB`, `mem_rdata`=`0x11223344`:
  - `mem_addr`=`0x200`;
  - `mem_wdata`=`0xAB223344`;
  - `done` in T+3.
- sh, addr `0x302`, data `0x0000CAFE`, `mem_rdata`=`0x11223344`, with 2 wait cycles on `mem_rvalid` and 1 on `mem_wack`:
  - `mem_wdata`=`0xCAFE3344`;
  - `mem_rd` held 3 cycles and `mem_wr` held 2 cycles;
  - `done` in T+6.
- sh at `0x301`, sw at `0x302`, and op `011`:
  - each gives an `err` pulse in T+1;
  - no `mem_rd`/`mem_wr`;
  - `req_ready` stays high.
- `rst_n` low while in WRITE:
  - `mem_wr` drops immediately;
  - no `done`;
  - `req_ready`=1;
  - a following sb completes normally.
- Stray `mem_wack`/`mem_rvalid` pulses while IDLE cause no state change and no output pulse.
